// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the two-requester multiplier-sharing block.
package mult_share_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int ID_W = 1;
  localparam int DEFAULT_SETTLE_CYCLES = 4;

endpackage

// File: rtl/mult_share_arbiter_rr.sv
// Two-input round-robin grant: on contention the requester that did not win last time wins.
module rr_arbiter2
  import mult_share_arbiter_pkg::*;
(
  input  logic            valid0,
  input  logic            valid1,
  input  logic [ID_W-1:0] last_grant,
  output logic [1:0]      grant
);

  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      grant = (last_grant == '0) ? 2'b10 : 2'b01;
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Time-shares one external combinational multiplier between two requesters,
// holding operands for a fixed settle time before capturing the product.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [2*WIDTH-1:0] rsp_product,
  output logic [WIDTH-1:0]   mult_a,
  output logic [WIDTH-1:0]   mult_b,
  input  logic [2*WIDTH-1:0] mult_p,
  output logic               busy
);

  localparam int CW = 4;

  state_t          state;
  logic [CW-1:0]   count;
  logic [ID_W-1:0] owner;
  logic [ID_W-1:0] last_grant;
  logic [1:0]      grant;
  logic            accept0;
  logic            accept1;
  logic            rsp_take;

  rr_arbiter2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Ready is only offered in IDLE so operands can never change under a pending multiply.
  assign req0_ready = (state == IDLE) && grant[0];
  assign req1_ready = (state == IDLE) && grant[1];
  assign accept0    = req0_valid && req0_ready;
  assign accept1    = req1_valid && req1_ready;
  assign rsp_take   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      owner       <= '0;
      last_grant  <= 1'b1;
      mult_a      <= '0;
      mult_b      <= '0;
      rsp_product <= '0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept0) begin
            mult_a     <= req0_a;
            mult_b     <= req0_b;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            count      <= CW'(SETTLE_CYCLES - 1);
            state      <= WAIT;
          end else if (accept1) begin
            mult_a     <= req1_a;
            mult_b     <= req1_b;
            owner      <= 1'b1;
            last_grant <= 1'b1;
            count      <= CW'(SETTLE_CYCLES - 1);
            state      <= WAIT;
          end
        end
        WAIT: begin
          // The last settle cycle is the one in which the product is sampled.
          if (count == '0) begin
            rsp_product <= mult_p;
            rsp0_valid  <= (owner == 1'b0);
            rsp1_valid  <= (owner == 1'b1);
            state       <= RESP;
          end else begin
            count <= count - 1'b1;
          end
        end
        RESP: begin
          if (rsp_take) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (reset) !(req0_ready && req1_ready));
  a_rsp_onehot:   assert property (@(posedge clk) disable iff (reset) !(rsp0_valid && rsp1_valid));

endmodule
